// File: rtl/snax_banked_mem_arb_if.sv
// -----------------------------------------------------------------------------
// snax_banked_mem_arb_if
//
// Bundles every request/response signal of the banked scratchpad into one
// interface.
//   master : the requesters (narrow interconnect + DMA). They drive requests
//            and receive ready/response.
//   slave  : the banked memory. It receives requests and drives
//            ready/response.
// Signals (bank i uses slice i of every packed per-bank vector):
//   narrow_req_{valid,addr,write,wdata,strb}_i / narrow_req_ready_o
//   narrow_rsp_{valid,data}_o
//   wide_req_{valid,addr,write,wdata,strb}_i   / wide_req_ready_o
//   wide_rsp_{valid,data}_o
// -----------------------------------------------------------------------------
interface snax_banked_mem_arb_if #(
    parameter int NumBanks        = 16,
    parameter int NarrowDataWidth = 32,
    parameter int BankAddrWidth   = 10
);
    localparam int StrbWidth = NarrowDataWidth / 8;

    logic [NumBanks-1:0]                  narrow_req_valid_i;
    logic [NumBanks-1:0]                  narrow_req_ready_o;
    logic [NumBanks*BankAddrWidth-1:0]    narrow_req_addr_i;
    logic [NumBanks-1:0]                  narrow_req_write_i;
    logic [NumBanks*NarrowDataWidth-1:0]  narrow_req_wdata_i;
    logic [NumBanks*StrbWidth-1:0]        narrow_req_strb_i;
    logic [NumBanks-1:0]                  narrow_rsp_valid_o;
    logic [NumBanks*NarrowDataWidth-1:0]  narrow_rsp_data_o;

    logic                                 wide_req_valid_i;
    logic                                 wide_req_ready_o;
    logic [BankAddrWidth-1:0]             wide_req_addr_i;
    logic                                 wide_req_write_i;
    logic [NumBanks*NarrowDataWidth-1:0]  wide_req_wdata_i;
    logic [NumBanks*StrbWidth-1:0]        wide_req_strb_i;
    logic                                 wide_rsp_valid_o;
    logic [NumBanks*NarrowDataWidth-1:0]  wide_rsp_data_o;

    modport master (
        output narrow_req_valid_i, narrow_req_addr_i, narrow_req_write_i,
               narrow_req_wdata_i, narrow_req_strb_i,
               wide_req_valid_i, wide_req_addr_i, wide_req_write_i,
               wide_req_wdata_i, wide_req_strb_i,
        input  narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_data_o,
               wide_req_ready_o, wide_rsp_valid_o, wide_rsp_data_o
    );

    modport slave (
        input  narrow_req_valid_i, narrow_req_addr_i, narrow_req_write_i,
               narrow_req_wdata_i, narrow_req_strb_i,
               wide_req_valid_i, wide_req_addr_i, wide_req_write_i,
               wide_req_wdata_i, wide_req_strb_i,
        output narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_data_o,
               wide_req_ready_o, wide_rsp_valid_o, wide_rsp_data_o
    );
endinterface

// File: rtl/snax_banked_mem_arb.sv
// -----------------------------------------------------------------------------
// snax_banked_mem_arb
//
// Multi-bank scratchpad. Each bank has its own narrow port. One wide port
// accesses the same word (row) in every bank at once. In every cycle each bank
// is given either to the wide row access or to its narrow port. Read data
// returns through a ReadLatency-deep pipeline.
//
// Ports:
//   clk_i  : clock. All state changes on the rising edge.
//   rst_i  : asynchronous active-high reset. It clears the response
//            pipeline and the starvation counters. Memory contents are kept.
//   bus    : snax_banked_mem_arb_if.slave, which carries the narrow and wide
//            request/response ports.
//
// Optional feature macro: SNAX_BANKED_MEM_STARVE_GUARD_EN
//   When defined, there is one saturating counter per bank. A bank whose
//   narrow request has lost StarveLimit times in a row blocks the wide port
//   for one cycle. When undefined, wide has strict priority.
// -----------------------------------------------------------------------------
module snax_banked_mem_arb #(
    parameter int NumBanks        = 16,
    parameter int NarrowDataWidth = 32,
    parameter int WordsPerBank    = 1024,
    parameter int ReadLatency     = 1,
    parameter int StarveLimit     = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    snax_banked_mem_arb_if.slave bus
);
    localparam int AW = $clog2(WordsPerBank);
    localparam int DW = NarrowDataWidth;
    localparam int SW = DW / 8;

    if (NumBanks < 2 || (DW % 8) != 0 || ReadLatency < 1 || ReadLatency > 4 ||
        StarveLimit < 1 || StarveLimit > 15) begin : g_bad_param
        $error("snax_banked_mem_arb: parameter out of range");
    end

    logic wide_grant;
    logic starve_override;

    // Per-bank access after arbitration.
    logic [NumBanks-1:0] bank_en;
    logic [NumBanks-1:0] bank_we;
    logic [NumBanks-1:0] bank_wide;
    logic [NumBanks-1:0] bank_inrange;
    logic [AW-1:0]       bank_addr  [NumBanks];
    logic [DW-1:0]       bank_wdata [NumBanks];
    logic [SW-1:0]       bank_strb  [NumBanks];
    logic [DW-1:0]       rd_data    [NumBanks];

    logic [DW-1:0]       mem_q [NumBanks][WordsPerBank];

    logic [ReadLatency-1:0] wide_vld_q;
    logic [NumBanks-1:0]    nar_vld_q [ReadLatency];
    logic [DW-1:0]          data_q    [ReadLatency][NumBanks];

    // ---------------------------------------------------------------- starve
`ifdef SNAX_BANKED_MEM_STARVE_GUARD_EN
    logic [3:0]          starve_cnt_q [NumBanks];
    logic [3:0]          starve_cnt_d [NumBanks];
    logic [NumBanks-1:0] starved;

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            starved[b]      = (starve_cnt_q[b] == 4'(StarveLimit));
            starve_cnt_d[b] = starve_cnt_q[b];
            if (bus.narrow_req_valid_i[b] && !wide_grant) begin
                starve_cnt_d[b] = '0;
            end else if (bus.narrow_req_valid_i[b] && wide_grant && !starved[b]) begin
                starve_cnt_d[b] = starve_cnt_q[b] + 4'd1;
            end
        end
    end

    assign starve_override = |starved;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) starve_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) starve_cnt_q[b] <= starve_cnt_d[b];
        end
    end
`else
    assign starve_override = 1'b0;
`endif

    // ------------------------------------------------------------ arbitration
    // Ready depends only on wide valid and the registered counters, never on
    // narrow valid. This keeps narrow valid off every combinational ready path.
    assign wide_grant             = bus.wide_req_valid_i & ~starve_override;
    assign bus.wide_req_ready_o   = ~starve_override;
    assign bus.narrow_req_ready_o = {NumBanks{~wide_grant}};

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            if (wide_grant) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = bus.wide_req_write_i;
                bank_wide[b]  = 1'b1;
                bank_addr[b]  = bus.wide_req_addr_i;
                bank_wdata[b] = bus.wide_req_wdata_i[b*DW +: DW];
                bank_strb[b]  = bus.wide_req_strb_i[b*SW +: SW];
            end else begin
                bank_en[b]    = bus.narrow_req_valid_i[b];
                bank_we[b]    = bus.narrow_req_write_i[b];
                bank_wide[b]  = 1'b0;
                bank_addr[b]  = bus.narrow_req_addr_i[b*AW +: AW];
                bank_wdata[b] = bus.narrow_req_wdata_i[b*DW +: DW];
                bank_strb[b]  = bus.narrow_req_strb_i[b*SW +: SW];
            end
            // Non-power-of-two depth: addresses beyond the last word are
            // treated as holes. Writes to them are dropped and reads return 0.
            bank_inrange[b] = (32'(bank_addr[b]) < WordsPerBank);
            rd_data[b]      = bank_inrange[b] ? mem_q[b][bank_addr[b]] : '0;
        end
    end

    // ----------------------------------------------------------------- memory
    // NOTE: the SRAM array has no reset branch. It is not cleared on reset,
    // and leaving reset off lets it map onto real bank macros.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            if (bank_en[b] && bank_we[b] && bank_inrange[b]) begin
                for (int k = 0; k < SW; k++) begin
                    if (bank_strb[b][k]) mem_q[b][bank_addr[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------- read pipeline
    // Narrow and wide reads to one bank never share a cycle. One data pipeline
    // per bank therefore serves both ports, and the two valid bits tag the owner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wide_vld_q <= '0;
            for (int s = 0; s < ReadLatency; s++) begin
                nar_vld_q[s] <= '0;
                for (int b = 0; b < NumBanks; b++) data_q[s][b] <= '0;
            end
        end else begin
            wide_vld_q[0] <= wide_grant & ~bus.wide_req_write_i;
            for (int b = 0; b < NumBanks; b++) begin
                nar_vld_q[0][b] <= bank_en[b] & ~bank_we[b] & ~bank_wide[b];
                data_q[0][b]    <= (bank_en[b] && !bank_we[b]) ? rd_data[b] : '0;
            end
            for (int s = 1; s < ReadLatency; s++) begin
                wide_vld_q[s] <= wide_vld_q[s-1];
                nar_vld_q[s]  <= nar_vld_q[s-1];
                data_q[s]     <= data_q[s-1];
            end
        end
    end

    assign bus.wide_rsp_valid_o   = wide_vld_q[ReadLatency-1];
    assign bus.narrow_rsp_valid_o = nar_vld_q[ReadLatency-1];

    always_comb begin
        bus.narrow_rsp_data_o = '0;
        for (int b = 0; b < NumBanks; b++) begin
            bus.narrow_rsp_data_o[b*DW +: DW] = data_q[ReadLatency-1][b];
        end
    end

    assign bus.wide_rsp_data_o = bus.narrow_rsp_data_o;

endmodule

// File: tb/tb_snax_banked_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_snax_banked_mem_arb
//
// Drives the banked scratchpad with a table of single-cycle request vectors,
// then with hand-written multi-cycle sequences: conflict, starvation and reset
// in flight. Expected read data comes from a byte-masked reference memory, or
// from literal constants. It is queued at the handshake and compared when a
// response appears.
// Uses the DUT with 8 banks, 1000 words per bank and ReadLatency 3.
// -----------------------------------------------------------------------------
module tb_snax_banked_mem_arb;
    localparam int NB  = 8;
    localparam int DW  = 32;
    localparam int WPB = 1000;
    localparam int AW  = $clog2(WPB);
    localparam int RL  = 3;
    localparam int SL  = 4;
    localparam int RW  = NB * DW;

    typedef logic [RW-1:0] word_t;

    typedef struct {
        logic          wv;
        logic          ww;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wseed;
        logic [NB-1:0] nv;
        logic [NB-1:0] nw;
        logic [AW-1:0] naddr;
        logic [DW-1:0] ndata;
        logic [3:0]    nstrb;
        logic          exp_wrdy;
        logic          exp_nrdy;
    } vec_t;

    typedef struct {
        logic  is_wide;
        int    bank;
        word_t data;
        int    due;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    rsp_t          sb_q[$];
    vec_t          tbl[$];
    logic [DW-1:0] mdl [NB][WPB];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    snax_banked_mem_arb_if #(.NumBanks(NB), .NarrowDataWidth(DW), .BankAddrWidth(AW)) bus ();

    snax_banked_mem_arb #(
        .NumBanks(NB), .NarrowDataWidth(DW), .WordsPerBank(WPB),
        .ReadLatency(RL), .StarveLimit(SL)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic logic [DW-1:0] model_read(input int b, input int addr);
        return (addr >= WPB) ? '0 : mdl[b][addr];
    endfunction

    task automatic model_write(input int b, input int addr, input logic [DW-1:0] d,
                               input logic [3:0] s);
        if (addr < WPB) begin
            for (int k = 0; k < 4; k++) if (s[k]) mdl[b][addr][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    // ---------------------------------------------------------- vector makers
    function automatic vec_t idle();
        vec_t v;
        v = '{wv: 1'b0, ww: 1'b0, waddr: '0, wseed: '0, nv: '0, nw: '0, naddr: '0,
              ndata: '0, nstrb: '0, exp_wrdy: 1'b1, exp_nrdy: 1'b1};
        return v;
    endfunction

    function automatic vec_t nar(input logic [NB-1:0] nv, input logic [NB-1:0] nw,
                                 input int addr, input logic [DW-1:0] d,
                                 input logic [3:0] s);
        vec_t v = idle();
        v.nv = nv; v.nw = nw; v.naddr = AW'(addr); v.ndata = d; v.nstrb = s;
        return v;
    endfunction

    function automatic vec_t wid(input logic w, input int addr, input logic [DW-1:0] seed);
        vec_t v = idle();
        v.wv = 1'b1; v.ww = w; v.waddr = AW'(addr); v.wseed = seed; v.exp_nrdy = 1'b0;
        return v;
    endfunction

    // Wide read of row waddr plus a narrow read on banks nv, with explicit readies.
    function automatic vec_t both(input int waddr, input logic [NB-1:0] nv, input int naddr,
                                  input logic wrdy, input logic nrdy);
        vec_t v = wid(1'b0, waddr, '0);
        v.nv = nv; v.naddr = AW'(naddr); v.exp_wrdy = wrdy; v.exp_nrdy = nrdy;
        return v;
    endfunction

    task automatic drive_idle();
        bus.wide_req_valid_i   = 1'b0;
        bus.wide_req_write_i   = 1'b0;
        bus.wide_req_addr_i    = '0;
        bus.wide_req_wdata_i   = '0;
        bus.wide_req_strb_i    = '0;
        bus.narrow_req_valid_i = '0;
        bus.narrow_req_write_i = '0;
        bus.narrow_req_addr_i  = '0;
        bus.narrow_req_wdata_i = '0;
        bus.narrow_req_strb_i  = '0;
    endtask

    // One clock of stimulus. Readies are checked against the vector. The
    // expected handshakes update the model and queue the expected responses.
    task automatic step(input vec_t v, input bit use_exp, input logic [DW-1:0] exp_nd);
        logic          wgo;
        logic [NB-1:0] ngo;
        word_t         row;
        @(negedge clk_i);
        bus.wide_req_valid_i = v.wv;
        bus.wide_req_write_i = v.ww;
        bus.wide_req_addr_i  = v.waddr;
        bus.wide_req_strb_i  = '1;
        for (int i = 0; i < NB; i++) begin
            bus.wide_req_wdata_i[i*DW +: DW]  = v.wseed + DW'(i);
            bus.narrow_req_addr_i[i*AW +: AW] = v.naddr;
            bus.narrow_req_wdata_i[i*DW +: DW] = v.ndata;
            bus.narrow_req_strb_i[i*4 +: 4]   = v.nstrb;
        end
        bus.narrow_req_valid_i = v.nv;
        bus.narrow_req_write_i = v.nw;
        #1;
        check("wide_ready", word_t'(bus.wide_req_ready_o), word_t'(v.exp_wrdy));
        check("narrow_ready", word_t'(bus.narrow_req_ready_o), word_t'({NB{v.exp_nrdy}}));
        wgo = v.wv & v.exp_wrdy;
        ngo = v.nv & {NB{v.exp_nrdy}};
        if (wgo) begin
            if (v.ww) begin
                for (int i = 0; i < NB; i++) model_write(i, int'(v.waddr), v.wseed + DW'(i), 4'hF);
            end else begin
                for (int i = 0; i < NB; i++) row[i*DW +: DW] = model_read(i, int'(v.waddr));
                sb_q.push_back('{is_wide: 1'b1, bank: 0, data: row, due: cyc + RL});
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (ngo[i]) begin
                if (v.nw[i]) model_write(i, int'(v.naddr), v.ndata, v.nstrb);
                else sb_q.push_back('{is_wide: 1'b0, bank: i,
                                      data: word_t'(use_exp ? exp_nd : model_read(i, int'(v.naddr))),
                                      due: cyc + RL});
            end
        end
        @(posedge clk_i);
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic take(input logic w, input int b, input word_t d);
        rsp_t e;
        check($sformatf("rsp_expected w%0d b%0d", w, b), word_t'(sb_q.size() != 0), word_t'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_owner", word_t'({w, 8'(b)}), word_t'({e.is_wide, 8'(e.bank)}));
            check("rsp_cycle", word_t'(cyc), word_t'(e.due));
            check($sformatf("rsp_data w%0d b%0d", w, b), d, e.data);
        end
    endtask

    always @(negedge clk_i) begin
        if (bus.wide_rsp_valid_o) take(1'b1, 0, bus.wide_rsp_data_o);
        for (int b = 0; b < NB; b++) begin
            if (bus.narrow_rsp_valid_o[b]) take(1'b0, b, word_t'(bus.narrow_rsp_data_o[b*DW +: DW]));
        end
        if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            check("rsp_overdue", word_t'(sb_q[0].due), word_t'(cyc));
            void'(sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- sequence
    initial begin
        drive_idle();
        #1;
        check("reset_wide_rsp_valid", word_t'(bus.wide_rsp_valid_o), '0);
        check("reset_narrow_rsp_valid", word_t'(bus.narrow_rsp_valid_o), '0);
        check("reset_rsp_data", bus.narrow_rsp_data_o, '0);
        check("reset_wide_ready", word_t'(bus.wide_req_ready_o), word_t'(1));
        check("reset_narrow_ready", word_t'(bus.narrow_req_ready_o), word_t'({NB{1'b1}}));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Single-cycle vectors. Expected data comes from the model.
        tbl.push_back(nar(8'hFF, 8'hFF, 'h100, 32'h0A0B0C0D, 4'hF));
        tbl.push_back(nar(8'hFF, 8'h00, 'h100, '0, '0));
        tbl.push_back(wid(1'b1, 'h200, 32'h1000));
        tbl.push_back(wid(1'b0, 'h200, '0));
        tbl.push_back(nar(8'h81, 8'h00, 'h200, '0, '0));
        tbl.push_back(nar(8'h04, 8'h04, 5, 32'h00000055, 4'hF));
        tbl.push_back(nar(8'h04, 8'h00, 5, '0, '0));
        tbl.push_back(nar(8'h04, 8'h04, 5, 32'h12345678, 4'h3));
        tbl.push_back(nar(8'h04, 8'h00, 5, '0, '0));
        tbl.push_back(nar(8'h04, 8'h00, 5, '0, '0));
        tbl.push_back(nar(8'h02, 8'h02, 1000, 32'h99999999, 4'hF));
        tbl.push_back(nar(8'h02, 8'h00, 1000, '0, '0));
        tbl.push_back(wid(1'b0, 1010, '0));
        tbl.push_back(wid(1'b1, 999, 32'h7700));
        tbl.push_back(wid(1'b0, 999, '0));
        tbl.push_back(nar(8'h40, 8'h00, 999, '0, '0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, '0);
        repeat (RL + 1) step(idle(), 1'b0, '0);

        // Write, then read back in the next cycle with literal expectations.
        step(nar(8'h08, 8'h08, 'h10, 32'hDEADBEEF, 4'hF), 1'b0, '0);
        step(nar(8'h08, 8'h00, 'h10, '0, '0), 1'b1, 32'hDEADBEEF);
        step(nar(8'h40, 8'h40, 'h30, 32'h11223344, 4'hF), 1'b0, '0);
        step(nar(8'h40, 8'h40, 'h30, 32'hAABBCCDD, 4'h5), 1'b0, '0);
        step(nar(8'h40, 8'h00, 'h30, '0, '0), 1'b1, 32'h11BB33DD);
        step(wid(1'b1, 7, 32'h0), 1'b0, '0);
        step(wid(1'b0, 7, '0), 1'b0, '0);
        step(nar(8'h20, 8'h00, 7, '0, '0), 1'b1, 32'd5);
        repeat (RL + 1) step(idle(), 1'b0, '0);

        // Conflict: wide wins, and narrow bank 0 holds and goes next cycle.
        step(both(7, 8'h01, 'h100, 1'b1, 1'b0), 1'b0, '0);
        step(nar(8'h01, 8'h00, 'h100, '0, '0), 1'b1, 32'h0A0B0C0D);
        repeat (RL + 1) step(idle(), 1'b0, '0);

        // Starvation of narrow bank 2 under a continuous wide stream.
`ifdef SNAX_BANKED_MEM_STARVE_GUARD_EN
        repeat (SL) step(both(7, 8'h04, 7, 1'b1, 1'b0), 1'b0, '0);
        step(both(7, 8'h04, 7, 1'b0, 1'b1), 1'b1, 32'd2);
`else
        repeat (2 * SL) step(both(7, 8'h04, 7, 1'b1, 1'b0), 1'b0, '0);
        step(nar(8'h04, 8'h00, 7, '0, '0), 1'b1, 32'd2);
`endif
        repeat (RL + 1) step(idle(), 1'b0, '0);

        // Reset while a read is in flight: no response, and the data survives.
        step(nar(8'h10, 8'h10, 'h20, 32'hCAFEF00D, 4'hF), 1'b0, '0);
        step(nar(8'h10, 8'h00, 'h20, '0, '0), 1'b0, '0);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        drive_idle();
        sb_q.delete();
        #1;
        check("midreset_narrow_rsp_valid", word_t'(bus.narrow_rsp_valid_o), '0);
        check("midreset_rsp_data", bus.narrow_rsp_data_o, '0);
        check("midreset_wide_ready", word_t'(bus.wide_req_ready_o), word_t'(1));
        check("midreset_narrow_ready", word_t'(bus.narrow_req_ready_o), word_t'({NB{1'b1}}));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (RL + 2) step(idle(), 1'b0, '0);
        step(nar(8'h10, 8'h00, 'h20, '0, '0), 1'b1, 32'hCAFEF00D);
        repeat (RL + 2) step(idle(), 1'b0, '0);

        check("scoreboard_drained", word_t'(sb_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snax_banked_mem_arb.md
# snax_banked_mem_arb

Parametrised multi-bank local scratchpad with per-bank narrow core ports and one wide DMA port sharing the same SRAM banks. Each cycle, a per-bank arbiter grants each bank to either the narrow port or the wide row access, then returns read data through a configurable-depth pipeline. It sits between the cluster narrow interconnect/DMA and the bank macros, replacing the fixed one-cycle, mode-signalled bank set. Arbitration is automatic and conflict-aware, and has no external DMA-mode pin.

## Interface
- NumBanks, 16, number of banks (≥2).
- NarrowDataWidth, 32, bank word width in bits (multiple of 8).
- WordsPerBank, 1024, depth of each bank; BankAddrWidth = $clog2(WordsPerBank).
- ReadLatency, 1, cycles from request handshake to response valid (1..4).
- StarveLimit, 4, consecutive narrow losses before forced narrow priority (1..15).
- clk_i  in  1  clock, all state rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- narrow_req_valid_i  in  NumBanks  per-bank request valid.
- narrow_req_ready_o  out  NumBanks  per-bank request accepted.
- narrow_req_addr_i  in  NumBanks*BankAddrWidth  word address within bank.
- narrow_req_write_i  in  NumBanks  1 = write.
- narrow_req_wdata_i  in  NumBanks*NarrowDataWidth  write data.
- narrow_req_strb_i  in  NumBanks*NarrowDataWidth/8  byte enables.
- narrow_rsp_valid_o  out  NumBanks  read data valid, one-cycle pulse.
- narrow_rsp_data_o  out  NumBanks*NarrowDataWidth  read data.
- wide_req_valid_i  in  1  wide row request valid.
- wide_req_ready_o  out  1  wide request accepted.
- wide_req_addr_i  in  BankAddrWidth  row index, same word in every bank.
- wide_req_write_i  in  1  1 = write.
- wide_req_wdata_i  in  NumBanks*NarrowDataWidth  bank i uses slice i.
- wide_req_strb_i  in  NumBanks*NarrowDataWidth/8  byte enables per slice.
- wide_rsp_valid_o  out  1  wide read data valid, one-cycle pulse.
- wide_rsp_data_o  out  NumBanks*NarrowDataWidth  full row read data.

## Operation
- Wide access is all-or-nothing: it owns every bank in the cycle it is granted.
- wide_grant = wide_req_valid_i & ~starve_override; wide_req_ready_o = ~starve_override.
- narrow_req_ready_o[i] = ~wide_grant. Combinational; no combinational path from narrow valid to any ready.
- Handshake = valid & ready. A request held with valid high must keep its payload stable until ready.
- Writes: byte-masked update at the handshake edge. No response is generated for writes.
- Reads: data captured into a ReadLatency-deep pipeline of valid+data per bank (narrow) and one row (wide). A tag bit records the owner so rsp_valid goes to exactly one port.
- Responses have no backpressure; the consumer must accept them.
- Memory contents are not reset. Simulation starts from X.
- Address ≥ WordsPerBank (non-power-of-two depth): write dropped, read returns 0, response still issued.

## Timing
- Read handshake at cycle t → rsp_valid high in cycle t+ReadLatency, for exactly one cycle.
- Throughput: one access per bank per cycle. Back-to-back reads produce back-to-back responses.
- Write at t, read of the same word at t+1 → returns the new data.
- Wide and narrow valid together without override → wide wins. Narrow ready is low that cycle, and narrow must hold.
- Reset asserted: all rsp_valid_o and pipeline valid bits clear immediately (async). rsp_data_o = 0. Starvation counters = 0. wide_req_ready_o = 1; narrow ready = 1 while wide valid is low.
- Reset mid-flight: in-flight reads are discarded with no response. A write that completed a handshake before reset persists.

## Configuration
- SNAX_BANKED_MEM_STARVE_GUARD_EN defined: one 4-bit saturating counter per bank.
  - Counter i increments when narrow_req_valid_i[i] & wide_grant, clears on a narrow handshake on bank i, and saturates at StarveLimit.
  - starve_override = any counter == StarveLimit. It blocks wide for that cycle, so every narrow is granted and the starved counter clears.
- Undefined: counters absent and starve_override = 0. Wide has strict priority; a continuous wide stream starves narrow indefinitely.

## Test plan
- Narrow write bank 3 addr 0x10 data 0xDEADBEEF strb 0xF, then read at t+1 → narrow_rsp_valid_o[3] at t+1+ReadLatency with data 0xDEADBEEF. No other bank's valid is high.
- Byte strobe: write 0x11223344 then 0xAABBCCDD with strb 0x5 to the same word → read returns 0x11BB33DD.
- Wide write row 7 with slice i = i, then wide read row 7 → wide_rsp_valid_o after ReadLatency, slice i = i. Narrow read of bank 5 addr 7 returns 5.
- Conflict: wide read and narrow bank 0 read valid in the same cycle → wide accepted, narrow ready low. Narrow is accepted the next cycle after wide drops, and responses come out in that order.
- Starve guard (macro on, StarveLimit=4): wide valid held high continuously with narrow bank 2 valid → wide_req_ready_o low on the 5th cycle and narrow 2 accepted then. Macro off: narrow 2 never accepted.
- Reset during a pending read with ReadLatency=3: assert rst_i 1 cycle after the handshake → no rsp_valid pulse. Previously written data is intact afterwards.
